// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control-unit bus: opcode/zero in, datapath controls out
interface multicycle_ctrl_if;
  logic [5:0] Opcode;
  logic       zero;
  logic [3:0] state;
  logic       PCWre;
  logic       IRWre;
  logic       InsMemRW;
  logic       ALUSrcB;
  logic       ALUM2Reg;
  logic       RegWre;
  logic       DataMemRW;
  logic       ExtSel;
  logic [1:0] RegOut;
  logic [1:0] PCSrc;
  logic [2:0] ALUOp;

  modport master (
    output Opcode, zero,
    input  state, PCWre, IRWre, InsMemRW, ALUSrcB, ALUM2Reg, RegWre,
           DataMemRW, ExtSel, RegOut, PCSrc, ALUOp
  );

  modport slave (
    input  Opcode, zero,
    output state, PCWre, IRWre, InsMemRW, ALUSrcB, ALUM2Reg, RegWre,
           DataMemRW, ExtSel, RegOut, PCSrc, ALUOp
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS-subset control FSM (CTRL_HALT_EN enables halt state)
module multicycle_ctrl (
  input  logic               CLK,
  input  logic               RST,
  multicycle_ctrl_if.slave   bus
);

  typedef enum logic [3:0] {
    S_IF     = 4'b0000,
    S_ID     = 4'b0001,
    S_EXE_LS = 4'b0010,
    S_MEM    = 4'b0011,
    S_WB_LD  = 4'b0100,
    S_EXE_BR = 4'b0101,
    S_EXE_AL = 4'b0110,
    S_WB_AL  = 4'b0111,
    S_HALT   = 4'b1000
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_ORI  = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_OR   = 6'b010010;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  state_t state_q, state_d;

  logic is_r, is_alu, is_imm, is_ls, is_halt, is_undef;
  logic [2:0] alu_op_dec;

  always_comb begin
    is_r    = (bus.Opcode == OP_ADD) || (bus.Opcode == OP_SUB) || (bus.Opcode == OP_AND) ||
              (bus.Opcode == OP_OR)  || (bus.Opcode == OP_SLT);
    is_imm  = (bus.Opcode == OP_ADDI) || (bus.Opcode == OP_ORI) ||
              (bus.Opcode == OP_LW)   || (bus.Opcode == OP_SW);
    is_alu  = is_r || (bus.Opcode == OP_ADDI) || (bus.Opcode == OP_ORI);
    is_ls   = (bus.Opcode == OP_LW) || (bus.Opcode == OP_SW);
`ifdef CTRL_HALT_EN
    is_halt = (bus.Opcode == OP_HALT);
`else
    is_halt = 1'b0;
`endif
    // With halt disabled, 111111 falls through here and retires as a 2-cycle NOP
    is_undef = !(is_alu || is_ls || is_halt ||
                 (bus.Opcode == OP_BEQ) || (bus.Opcode == OP_J));
  end

  always_comb begin
    alu_op_dec = 3'b000;
    case (bus.Opcode)
      OP_SUB, OP_BEQ: alu_op_dec = 3'b001;
      OP_SLT:         alu_op_dec = 3'b010;
      OP_OR, OP_ORI:  alu_op_dec = 3'b011;
      OP_AND:         alu_op_dec = 3'b100;
      default:        alu_op_dec = 3'b000;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_IF;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (bus.Opcode == OP_BEQ) state_d = S_EXE_BR;
        else if (is_ls)           state_d = S_EXE_LS;
        else if (is_alu)          state_d = S_EXE_AL;
        else if (is_halt)         state_d = S_HALT;
        else                      state_d = S_IF;
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_EXE_LS: state_d = S_MEM;
      S_MEM:    state_d = (bus.Opcode == OP_SW) ? S_IF : S_WB_LD;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IF;
    endcase
  end

  always_comb begin
    bus.state     = state_q;
    bus.InsMemRW  = 1'b1;
    bus.IRWre     = 1'b0;
    bus.PCWre     = 1'b0;
    bus.PCSrc     = 2'b00;
    bus.RegWre    = 1'b0;
    bus.ALUM2Reg  = 1'b0;
    bus.DataMemRW = 1'b0;
    bus.ALUSrcB   = is_imm;
    bus.ExtSel    = (bus.Opcode != OP_ORI);
    bus.RegOut    = is_r ? 2'b01 : 2'b00;
    bus.ALUOp     = alu_op_dec;
    case (state_q)
      S_IF: bus.IRWre = 1'b1;
      S_ID: begin
        if (bus.Opcode == OP_J) begin
          bus.PCWre = 1'b1;
          bus.PCSrc = 2'b10;
        end else if (is_undef) begin
          bus.PCWre = 1'b1;
        end
      end
      S_EXE_BR: begin
        bus.PCWre = 1'b1;
        bus.PCSrc = bus.zero ? 2'b01 : 2'b00;
      end
      S_MEM: begin
        if (bus.Opcode == OP_SW) begin
          bus.PCWre     = 1'b1;
          bus.DataMemRW = 1'b1;
        end
      end
      S_WB_AL: begin
        bus.PCWre  = 1'b1;
        bus.RegWre = 1'b1;
      end
      S_WB_LD: begin
        bus.PCWre    = 1'b1;
        bus.RegWre   = 1'b1;
        bus.ALUM2Reg = 1'b1;
      end
      S_HALT: begin
        bus.ALUSrcB = 1'b0;
        bus.ExtSel  = 1'b0;
        bus.RegOut  = 2'b00;
        bus.ALUOp   = 3'b000;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed-vector bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic CLK;
  logic RST;
  int   n_vec;
  int   n_bad;
  logic [18:0] expq[$];

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {state, PCWre, IRWre, InsMemRW, ALUSrcB, ALUM2Reg, RegWre, DataMemRW, ExtSel, RegOut, PCSrc, ALUOp}
  function automatic logic [18:0] ev(input logic [3:0] st, input bit pcw, input bit irw,
                                     input bit asb, input bit m2r, input bit rw, input bit dmw,
                                     input bit ext, input logic [1:0] ro, input logic [1:0] pcs,
                                     input logic [2:0] aop);
    return {st, pcw, irw, 1'b1, asb, m2r, rw, dmw, ext, ro, pcs, aop};
  endfunction

  function automatic logic [18:0] obs();
    return {bus.state, bus.PCWre, bus.IRWre, bus.InsMemRW, bus.ALUSrcB, bus.ALUM2Reg,
            bus.RegWre, bus.DataMemRW, bus.ExtSel, bus.RegOut, bus.PCSrc, bus.ALUOp};
  endfunction

  task automatic next_cyc();
    @(posedge CLK);
    @(negedge CLK);
    #1;
  endtask

  // Entered at the IF negedge; leaves at the next instruction's IF negedge.
  task automatic run(input string nm, input logic [5:0] op, input logic z, input bit flip_zero);
    bus.Opcode = op;
    bus.zero   = z;
    #1;
    foreach (expq[i]) begin
      if (i > 0) next_cyc();
      check($sformatf("%s_c%0d", nm, i), {13'd0, obs()}, {13'd0, expq[i]});
    end
    if (flip_zero) begin
      bus.zero = ~z;
      #1;
      check({nm, "_zero_flip_pcsrc"}, {30'd0, bus.PCSrc}, {30'd0, (~z) ? 2'b01 : 2'b00});
    end
    expq.delete();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic alu(input string nm, input logic [5:0] op, input bit asb, input bit ext,
                     input logic [1:0] ro, input logic [2:0] aop);
    expq.push_back(ev(4'd0, 0, 1, asb, 0, 0, 0, ext, ro, 2'b00, aop));
    expq.push_back(ev(4'd1, 0, 0, asb, 0, 0, 0, ext, ro, 2'b00, aop));
    expq.push_back(ev(4'd6, 0, 0, asb, 0, 0, 0, ext, ro, 2'b00, aop));
    expq.push_back(ev(4'd7, 1, 0, asb, 0, 1, 0, ext, ro, 2'b00, aop));
    run(nm, op, 1'b1, 0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    RST = 1'b0;
    bus.Opcode = 6'b000000;
    bus.zero = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      #1;
      check($sformatf("rst_state_%0d", i), {28'd0, bus.state}, 32'd0);
      check($sformatf("rst_irwre_%0d", i), {31'd0, bus.IRWre}, 32'd1);
      check($sformatf("rst_pcwre_%0d", i), {31'd0, bus.PCWre}, 32'd0);
      check($sformatf("rst_regwre_%0d", i), {31'd0, bus.RegWre}, 32'd0);
      check($sformatf("rst_insmem_%0d", i), {31'd0, bus.InsMemRW}, 32'd1);
    end
    @(negedge CLK);
    RST = 1'b1;

    alu("add", 6'b000000, 0, 1, 2'b01, 3'b000);

    expq.push_back(ev(4'd0, 0, 1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000));
    expq.push_back(ev(4'd1, 0, 0, 1, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000));
    expq.push_back(ev(4'd2, 0, 0, 1, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000));
    expq.push_back(ev(4'd3, 0, 0, 1, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000));
    expq.push_back(ev(4'd4, 1, 0, 1, 1, 1, 0, 1, 2'b00, 2'b00, 3'b000));
    run("lw", 6'b110001, 1'b0, 0);

    expq.push_back(ev(4'd0, 0, 1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000));
    expq.push_back(ev(4'd1, 0, 0, 1, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000));
    expq.push_back(ev(4'd2, 0, 0, 1, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000));
    expq.push_back(ev(4'd3, 1, 0, 1, 0, 0, 1, 1, 2'b00, 2'b00, 3'b000));
    run("sw", 6'b110000, 1'b0, 0);

    expq.push_back(ev(4'd0, 0, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b001));
    expq.push_back(ev(4'd1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b001));
    expq.push_back(ev(4'd5, 1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b001));
    run("beq_z1", 6'b110100, 1'b1, 0);

    expq.push_back(ev(4'd0, 0, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b001));
    expq.push_back(ev(4'd1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b001));
    expq.push_back(ev(4'd5, 1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b001));
    run("beq_z0", 6'b110100, 1'b0, 1);

    alu("ori", 6'b010000, 1, 0, 2'b00, 3'b011);

    expq.push_back(ev(4'd0, 0, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000));
    expq.push_back(ev(4'd1, 1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 3'b000));
    run("j", 6'b111000, 1'b0, 0);
    #1;
    check("j_back_in_if", {28'd0, bus.state}, 32'd0);

    alu("sub",  6'b000001, 0, 1, 2'b01, 3'b001);
    alu("and",  6'b010001, 0, 1, 2'b01, 3'b100);
    alu("or",   6'b010010, 0, 1, 2'b01, 3'b011);
    alu("slt",  6'b100110, 0, 1, 2'b01, 3'b010);
    alu("addi", 6'b000010, 1, 1, 2'b00, 3'b000);

    expq.push_back(ev(4'd0, 0, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000));
    expq.push_back(ev(4'd1, 1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000));
    run("undef", 6'b000011, 1'b0, 0);

    bus.Opcode = 6'b110000;
    #1;
    check("abort_if", {28'd0, bus.state}, 32'd0);
    next_cyc();
    next_cyc();
    next_cyc();
    check("abort_mem_state", {28'd0, bus.state}, 32'd3);
    check("abort_mem_dmw", {31'd0, bus.DataMemRW}, 32'd1);
    RST = 1'b0;
    #1;
    check("abort_state", {28'd0, bus.state}, 32'd0);
    check("abort_dmw", {31'd0, bus.DataMemRW}, 32'd0);
    check("abort_pcwre", {31'd0, bus.PCWre}, 32'd0);
    @(posedge CLK);
    #1;
    check("abort_hold_pcwre", {31'd0, bus.PCWre}, 32'd0);
    check("abort_hold_regwre", {31'd0, bus.RegWre}, 32'd0);
    check("abort_hold_state", {28'd0, bus.state}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;

    bus.Opcode = 6'b111111;
    #1;
    check("halt_if", {13'd0, obs()}, {13'd0, ev(4'd0, 0, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000)});
    next_cyc();
`ifdef CTRL_HALT_EN
    check("halt_id", {13'd0, obs()}, {13'd0, ev(4'd1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000)});
    for (int i = 0; i < 20; i++) begin
      next_cyc();
      check($sformatf("halt_hold_%0d", i), {13'd0, obs()},
            {13'd0, ev(4'd8, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000)});
    end
`else
    check("halt_id_nop", {13'd0, obs()}, {13'd0, ev(4'd1, 1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000)});
    next_cyc();
    check("halt_nop_back_if", {28'd0, bus.state}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
